// File: rtl/vx_dvstack_unit.sv
// Per-warp divergence stack: a divergent split pushes an else-path level, joins resume the else path and then pop.
// Define DVSTACK_ERRCHK_EN to get sticky overflow/underflow flags and simulation assertions on those events.
module vx_dvstack_unit #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter int DEPTH       = 4,
  parameter int NWW         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int PTRW        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ctl_valid,
  input  logic [NWW-1:0]         ctl_wid,
  input  logic                   split_valid,
  input  logic                   split_is_dvg,
  input  logic [NUM_THREADS-1:0] split_then_tmask,
  input  logic [NUM_THREADS-1:0] split_else_tmask,
  input  logic [PC_BITS-1:0]     split_next_pc,
  input  logic [NUM_THREADS-1:0] split_cur_tmask,
  input  logic                   join_valid,
  input  logic [PTRW-1:0]        join_stack_ptr,
  input  logic [NWW-1:0]         query_wid,
  output logic [PTRW-1:0]        query_ptr,
  output logic                   rsp_valid,
  output logic [NWW-1:0]         rsp_wid,
  output logic [NUM_THREADS-1:0] rsp_tmask,
  output logic [PC_BITS-1:0]     rsp_pc,
  output logic                   rsp_pc_valid,
  output logic                   rsp_noop,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTRW-1:0]        ptr_q        [NUM_WARPS];
  logic [DEPTH-1:0]       else_done_q  [NUM_WARPS];
  logic [NUM_THREADS-1:0] orig_tmask_q [NUM_WARPS][DEPTH];
  logic [NUM_THREADS-1:0] else_tmask_q [NUM_WARPS][DEPTH];
  logic [PC_BITS-1:0]     else_pc_q    [NUM_WARPS][DEPTH];

  logic [PTRW-1:0]        cur_ptr;
  logic [LW-1:0]          push_idx;
  logic [LW-1:0]          top_idx;
  logic                   do_split;
  logic                   do_join;
  logic                   push;
  logic                   ovf_evt;
  logic                   unf_evt;
  logic                   join_else;
  logic                   join_pop;
  logic [NUM_THREADS-1:0] nxt_tmask;
  logic [PC_BITS-1:0]     nxt_pc;
  logic                   nxt_pc_valid;
  logic                   nxt_noop;

  assign query_ptr = ptr_q[query_wid];

  // A split wins over a join in the same command; noop responses echo split_cur_tmask as the unchanged mask.
  always_comb begin
    cur_ptr      = ptr_q[ctl_wid];
    push_idx     = LW'(cur_ptr);
    top_idx      = LW'(cur_ptr - PTRW'(1));
    do_split     = ctl_valid & split_valid;
    do_join      = ctl_valid & join_valid & ~split_valid;
    push         = do_split & split_is_dvg & (cur_ptr != PTRW'(DEPTH));
    ovf_evt      = do_split & split_is_dvg & (cur_ptr == PTRW'(DEPTH));
    unf_evt      = do_join & (join_stack_ptr != cur_ptr) & (cur_ptr == '0);
    join_else    = do_join & (join_stack_ptr != cur_ptr) & (cur_ptr != '0)
                   & ~else_done_q[ctl_wid][top_idx];
    join_pop     = do_join & (join_stack_ptr != cur_ptr) & (cur_ptr != '0)
                   & else_done_q[ctl_wid][top_idx];
    nxt_tmask    = split_cur_tmask;
    nxt_pc       = '0;
    nxt_pc_valid = 1'b0;
    nxt_noop     = 1'b1;
    if (push) begin
      nxt_tmask = split_then_tmask;
      nxt_noop  = 1'b0;
    end else if (join_else) begin
      nxt_tmask    = else_tmask_q[ctl_wid][top_idx];
      nxt_pc       = else_pc_q[ctl_wid][top_idx];
      nxt_pc_valid = 1'b1;
      nxt_noop     = 1'b0;
    end else if (join_pop) begin
      nxt_tmask = orig_tmask_q[ctl_wid][top_idx];
      nxt_noop  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        ptr_q[w]       <= '0;
        else_done_q[w] <= '0;
      end
    end else begin
      if (push) begin
        ptr_q[ctl_wid]                <= cur_ptr + PTRW'(1);
        else_done_q[ctl_wid][push_idx] <= 1'b0;
      end
      if (join_else) begin
        else_done_q[ctl_wid][top_idx] <= 1'b1;
      end
      if (join_pop) begin
        ptr_q[ctl_wid] <= cur_ptr - PTRW'(1);
      end
    end
  end

  // Level payload is never reset; else_done and ptr alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      orig_tmask_q[ctl_wid][push_idx] <= split_cur_tmask;
      else_tmask_q[ctl_wid][push_idx] <= split_else_tmask;
      else_pc_q[ctl_wid][push_idx]    <= split_next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid    <= 1'b0;
      rsp_wid      <= '0;
      rsp_tmask    <= '0;
      rsp_pc       <= '0;
      rsp_pc_valid <= 1'b0;
      rsp_noop     <= 1'b0;
    end else begin
      rsp_valid    <= ctl_valid & (split_valid | join_valid);
      rsp_wid      <= ctl_wid;
      rsp_tmask    <= nxt_tmask;
      rsp_pc       <= nxt_pc;
      rsp_pc_valid <= nxt_pc_valid;
      rsp_noop     <= nxt_noop;
    end
  end

`ifdef DVSTACK_ERRCHK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= err_overflow | ovf_evt;
      err_underflow <= err_underflow | unf_evt;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      ovf_check: assert (!ovf_evt);
      unf_check: assert (!unf_evt);
    end
  end
`else
  logic unused_err;
  assign unused_err    = ovf_evt | unf_evt;
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_vx_dvstack_unit.sv
// Scoreboard bench for vx_dvstack_unit: a level-stack reference model predicts each response and pointer.
module tb_vx_dvstack_unit;

  localparam int NW    = 4;
  localparam int NT    = 4;
  localparam int PCB   = 30;
  localparam int DEPTH = 4;
  localparam int NWW   = 2;
  localparam int PTRW  = 3;
`ifdef DVSTACK_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            ctl_valid;
  logic [NWW-1:0]  ctl_wid;
  logic            split_valid;
  logic            split_is_dvg;
  logic [NT-1:0]   split_then_tmask;
  logic [NT-1:0]   split_else_tmask;
  logic [PCB-1:0]  split_next_pc;
  logic [NT-1:0]   split_cur_tmask;
  logic            join_valid;
  logic [PTRW-1:0] join_stack_ptr;
  logic [NWW-1:0]  query_wid;
  logic [PTRW-1:0] query_ptr;
  logic            rsp_valid;
  logic [NWW-1:0]  rsp_wid;
  logic [NT-1:0]   rsp_tmask;
  logic [PCB-1:0]  rsp_pc;
  logic            rsp_pc_valid;
  logic            rsp_noop;
  logic            err_overflow;
  logic            err_underflow;

  vx_dvstack_unit #(
    .NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .ctl_valid(ctl_valid), .ctl_wid(ctl_wid),
    .split_valid(split_valid), .split_is_dvg(split_is_dvg),
    .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask),
    .split_next_pc(split_next_pc), .split_cur_tmask(split_cur_tmask),
    .join_valid(join_valid), .join_stack_ptr(join_stack_ptr),
    .query_wid(query_wid), .query_ptr(query_ptr),
    .rsp_valid(rsp_valid), .rsp_wid(rsp_wid), .rsp_tmask(rsp_tmask), .rsp_pc(rsp_pc),
    .rsp_pc_valid(rsp_pc_valid), .rsp_noop(rsp_noop),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0]  orig;
    logic [NT-1:0]  els;
    logic [PCB-1:0] pc;
    bit             done;
  } lvl_t;

  typedef struct {
    int             wid;
    logic [NT-1:0]  tmask;
    logic [PCB-1:0] pc;
    bit             pc_valid;
    bit             noop;
    bit             ovf;
    bit             unf;
  } exp_t;

  lvl_t          stk      [NW][DEPTH];
  int            depth_of [NW];
  logic [NT-1:0] cur_mask [NW];
  bit            ovf_m;
  bit            unf_m;
  exp_t          sbq [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic resetModel();
    for (int w = 0; w < NW; w++) begin
      depth_of[w] = 0;
      cur_mask[w] = '1;
    end
    ovf_m = 1'b0;
    unf_m = 1'b0;
    sbq.delete();
  endtask

  task automatic checkQuery(input int w);
    query_wid = NWW'(w);
    #1;
    cmp($sformatf("query_ptr[w%0d]", w), 64'(query_ptr), 64'(depth_of[w]));
  endtask

  // Monitor side: pops one prediction per presented response.
  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 wid=%0d, expected no response", rsp_wid);
    end else begin
      e = sbq.pop_front();
      cmp("rsp_wid", 64'(rsp_wid), 64'(e.wid));
      cmp("rsp_tmask", 64'(rsp_tmask), 64'(e.tmask));
      cmp("rsp_noop", 64'(rsp_noop), 64'(e.noop));
      cmp("rsp_pc_valid", 64'(rsp_pc_valid), 64'(e.pc_valid));
      if (e.pc_valid) cmp("rsp_pc", 64'(rsp_pc), 64'(e.pc));
      cmp("err_overflow", 64'(err_overflow), 64'(e.ovf));
      cmp("err_underflow", 64'(err_underflow), 64'(e.unf));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && rsp_valid) checkOutput();
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycle();
    nextCycle();
    ctl_valid   = 1'b0;
    split_valid = 1'b0;
    join_valid  = 1'b0;
  endtask

  // Called 2 time units after a rising edge: checks a random pointer, then drives one command and predicts it.
  task automatic applyStimulus(input bit sp, input bit jn, input int w, input bit dvg,
                               input logic [NT-1:0] cur, input logic [NT-1:0] thn,
                               input logic [NT-1:0] els, input logic [PCB-1:0] pc, input int jsp);
    exp_t e;
    int   d;
    checkQuery($urandom_range(0, NW - 1));
    ctl_valid        = 1'b1;
    ctl_wid          = NWW'(w);
    split_valid      = sp;
    split_is_dvg     = dvg;
    split_cur_tmask  = cur;
    split_then_tmask = thn;
    split_else_tmask = els;
    split_next_pc    = pc;
    join_valid       = jn;
    join_stack_ptr   = PTRW'(jsp);
    if (!sp && !jn) return;
    d          = depth_of[w];
    e.wid      = w;
    e.tmask    = cur;
    e.pc       = '0;
    e.pc_valid = 1'b0;
    e.noop     = 1'b1;
    if (sp) begin
      if (dvg && d < DEPTH) begin
        stk[w][d].orig = cur;
        stk[w][d].els  = els;
        stk[w][d].pc   = pc;
        stk[w][d].done = 1'b0;
        depth_of[w]    = d + 1;
        e.tmask        = thn;
        e.noop         = 1'b0;
      end else if (dvg) begin
        ovf_m = 1'b1;
      end
    end else if (jsp != d) begin
      if (d == 0) begin
        unf_m = 1'b1;
      end else if (!stk[w][d-1].done) begin
        stk[w][d-1].done = 1'b1;
        e.tmask    = stk[w][d-1].els;
        e.pc       = stk[w][d-1].pc;
        e.pc_valid = 1'b1;
        e.noop     = 1'b0;
      end else begin
        depth_of[w] = d - 1;
        e.tmask     = stk[w][d-1].orig;
        e.noop      = 1'b0;
      end
    end
    e.ovf       = ERRCHK && ovf_m;
    e.unf       = ERRCHK && unf_m;
    cur_mask[w] = e.tmask;
    sbq.push_back(e);
  endtask

  task automatic issue(input bit sp, input bit jn, input int w, input bit dvg,
                       input logic [NT-1:0] cur, input logic [NT-1:0] thn,
                       input logic [NT-1:0] els, input logic [PCB-1:0] pc, input int jsp);
    nextCycle();
    applyStimulus(sp, jn, w, dvg, cur, thn, els, pc, jsp);
  endtask

  task automatic randomSplit(input int w, input bit dvg);
    logic [NT-1:0] thn;
    thn = cur_mask[w] & NT'($urandom);
    issue(1'b1, 1'b0, w, dvg, cur_mask[w], thn, cur_mask[w] & ~thn, PCB'($urandom), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r;
    int w;
    int jsp;
    int waits;
    reset            = 1'b0;
    ctl_valid        = 1'b0;
    ctl_wid          = '0;
    split_valid      = 1'b0;
    split_is_dvg     = 1'b0;
    split_then_tmask = '0;
    split_else_tmask = '0;
    split_next_pc    = '0;
    split_cur_tmask  = '0;
    join_valid       = 1'b0;
    join_stack_ptr   = '0;
    query_wid        = '0;
    resetModel();

    #12;
    cmp("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    cmp("reset_err_overflow", 64'(err_overflow), 64'd0);
    cmp("reset_err_underflow", 64'(err_underflow), 64'd0);
    for (int i = 0; i < NW; i++) checkQuery(i);

    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1, 1'b1, 4'b1111, 4'b0011, 4'b1100, 30'h40, 0);
    idleCycle();
    checkQuery(1);
    issue(1'b0, 1'b1, 1, 1'b0, cur_mask[1], 4'b0000, 4'b0000, 30'h0, 0);
    idleCycle();
    checkQuery(1);
    issue(1'b0, 1'b1, 1, 1'b0, cur_mask[1], 4'b0000, 4'b0000, 30'h0, 0);
    idleCycle();
    checkQuery(1);

    issue(1'b1, 1'b0, 2, 1'b0, 4'b1010, 4'b0010, 4'b1000, 30'h88, 0);
    issue(1'b0, 1'b1, 2, 1'b0, 4'b1010, 4'b0000, 4'b0000, 30'h0, 0);
    idleCycle();
    checkQuery(2);

    issue(1'b0, 1'b1, 2, 1'b0, cur_mask[2], 4'b0000, 4'b0000, 30'h0, 1);
    issue(1'b1, 1'b1, 3, 1'b1, 4'b1111, 4'b0110, 4'b1001, 30'h123, 0);
    issue(1'b0, 1'b0, 1, 1'b1, 4'b1111, 4'b0001, 4'b1110, 30'h7, 0);

    randomSplit(0, 1'b1);
    randomSplit(3, 1'b1);
    randomSplit(0, 1'b1);
    randomSplit(3, 1'b1);
    nextCycle();
    ctl_valid   = 1'b0;
    split_valid = 1'b0;
    checkQuery(0);
    checkQuery(3);
    reset = 1'b0;
    #1;
    cmp("rsp_valid_async_reset", 64'(rsp_valid), 64'd0);
    resetModel();
    for (int i = 0; i < NW; i++) checkQuery(i);

    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 0, 1'b1, cur_mask[0], 4'b0101, 4'b1010, 30'h100, 0);
    for (int i = 0; i < DEPTH; i++) randomSplit(0, 1'b1);
    idleCycle();
    checkQuery(0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      w = $urandom_range(0, NW - 1);
      if (r < 40) begin
        randomSplit(w, r < 30);
      end else if (r < 85) begin
        case ($urandom_range(0, 3))
          0:       jsp = depth_of[w];
          3:       jsp = $urandom_range(0, DEPTH);
          default: jsp = (depth_of[w] > 0) ? depth_of[w] - 1 : 0;
        endcase
        issue(1'b0, 1'b1, w, 1'b0, cur_mask[w], 4'b0000, 4'b0000, 30'h0, jsp);
      end else if (r < 90) begin
        issue(1'b1, 1'b1, w, 1'b1, cur_mask[w], cur_mask[w] & 4'b0011,
              cur_mask[w] & 4'b1100, PCB'($urandom), 0);
      end else if (r < 94) begin
        issue(1'b0, 1'b0, w, 1'b0, cur_mask[w], 4'b0000, 4'b0000, 30'h0, 0);
      end else begin
        idleCycle();
      end
    end

    idleCycle();
    waits = 0;
    while (sbq.size() != 0 && waits < 5) begin
      idleCycle();
      waits++;
    end
    cmp("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_dvstack_unit.md
VX_DVSTACK_UNIT -- requirements
Module: vx_dvstack_unit

Interface
REQ-001 SHALL have parameters: NUM_WARPS, default 4, warp count; NUM_THREADS, default 4, mask width NT; PC_BITS, default 30, PC width; DEPTH, default 4, stack levels per warp. Derived widths: NWW = max(1, clog2(NUM_WARPS)); PTRW = clog2(DEPTH+1).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- ctl_valid  in  1  warp-control command strobe
- ctl_wid  in  NWW  target warp
- split_valid  in  1  command is split
- split_is_dvg  in  1  split diverges
- split_then_tmask  in  NT  then-path mask
- split_else_tmask  in  NT  else-path mask
- split_next_pc  in  PC_BITS  else-path resume PC
- split_cur_tmask  in  NT  warp mask before split
- join_valid  in  1  command is join
- join_stack_ptr  in  PTRW  pointer value captured at split
- query_wid  in  NWW  pointer query warp
- query_ptr  out  PTRW  current stack pointer of query_wid
- rsp_valid  out  1  scheduler update strobe
- rsp_wid  out  NWW  updated warp
- rsp_tmask  out  NT  new warp mask
- rsp_pc  out  PC_BITS  redirect PC
- rsp_pc_valid  out  1  apply rsp_pc
- rsp_noop  out  1  no state change; mask unchanged
- err_overflow  out  1  sticky overflow flag
- err_underflow  out  1  sticky underflow flag

Function
REQ-003 SHALL keep per warp: ptr (PTRW), and per level {orig_tmask, else_tmask, else_pc, else_done}.
REQ-004 query_ptr SHALL be combinational from registered ptr[query_wid]; there is no bypass of a same-cycle update.
REQ-005 Every response SHALL be registered, with rsp_valid exactly 1 cycle after ctl_valid; rsp_wid equals the registered ctl_wid; the block takes no backpressure.
REQ-006 ctl_valid with neither split_valid nor join_valid SHALL be ignored and produce no response.
REQ-007 Split with is_dvg=1 and ptr<DEPTH SHALL write level[ptr] = {cur_tmask, else_tmask, next_pc, 0} and increment ptr; the response is tmask=then_tmask, pc_valid=0, noop=0.
REQ-008 Split with is_dvg=0 SHALL leave the stack unchanged; the response is tmask=cur_tmask, noop=1.
REQ-009 Split with is_dvg=1 at ptr==DEPTH SHALL leave the stack unchanged, respond as REQ-008, and set err_overflow.
REQ-010 Join with join_stack_ptr==ptr SHALL be a non-divergent join: stack unchanged, noop=1.
REQ-011 Join with top=level[ptr-1] and else_done=0 SHALL set else_done; the response is tmask=else_tmask, pc=else_pc, pc_valid=1.
REQ-012 Join with else_done=1 SHALL decrement ptr; the response is tmask=orig_tmask, pc_valid=0, noop=0.
REQ-013 Join at ptr==0 with join_stack_ptr!=0 SHALL respond noop=1 and set err_underflow.
REQ-014 split_valid and join_valid both high SHALL execute the split only.
REQ-015 Per-warp state SHALL be independent; back-to-back commands to any warps SHALL be accepted every cycle.

Reset
REQ-016 Asserting reset (low) SHALL asynchronously clear all ptr, else_done, rsp_valid, rsp_pc_valid, rsp_noop, err_overflow and err_underflow. Level data is not cleared. A response pending at reset is discarded.
REQ-017 After reset deasserts, the first command SHALL be accepted on the next rising edge.

Configuration
REQ-018 With DVSTACK_ERRCHK_EN defined, err_overflow and err_underflow SHALL be sticky until reset, and a simulation assertion SHALL fire on each overflow and underflow event.
REQ-019 Without DVSTACK_ERRCHK_EN, both flags SHALL be tied 0 and no assertions compiled; the guarded behaviour of REQ-009 and REQ-013 is unchanged.

Verification
REQ-020 Warp1 split dvg, cur=1111, then=0011, else=1100, pc=0x40:
- query_ptr(1) goes 0->1.
- Response next cycle: tmask=0011, noop=0.
REQ-021 Then join(ptr=0) on warp1:
- Response: tmask=1100, pc=0x40, pc_valid=1; ptr stays 1.
- Second join: tmask=1111, pc_valid=0; ptr=0.
REQ-022 Non-dvg split cur=1010, then join(ptr=0):
- Both responses: noop=1, tmask=1010; ptr stays 0.
REQ-023 DEPTH+1 nested dvg splits on warp0:
- ptr saturates at 4.
- Fifth split gives noop=1 and err_overflow=1 (macro on) / 0 (macro off).
REQ-024 Interleaved splits on warp0 and warp3 on consecutive cycles:
- Independent pointers and correct masks.
- Reset low mid-sequence clears all pointers and rsp_valid immediately.
